// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the motherboard bus controller: FSM states, grant
// identities and the bit positions used on mobo_ctrl / mobo_stat.
// Imported by the arbiter and the controller top.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Grant identity; also the bit index in the arbiter's one-hot grant.
  typedef enum logic {
    GNT_F = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int CTRL_RD    = 0;
  localparam int CTRL_WR    = 1;
  localparam int STAT_READY = 0;
  localparam int STAT_ERROR = 1;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Requester handshakes (fetch port F, data port D) plus the motherboard bus pins.
// The controller uses the slave modport.
// The master modport is the CPU/board side.
interface mem_bus_ctrl_if #(
  parameter int word_width = 32
);
  logic                  f_req;
  logic [word_width-1:0] f_addr;
  logic                  f_ack;
  logic                  f_err;
  logic [word_width-1:0] f_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [word_width-1:0] d_addr;
  logic [word_width-1:0] d_wdata;
  logic                  d_ack;
  logic                  d_err;
  logic [word_width-1:0] d_rdata;

  logic [word_width-1:0] mobo_ctrl;
  logic [word_width-1:0] mobo_stat;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] data_out;
  logic [word_width-1:0] data_in;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mobo_stat, data_in,
    output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, mobo_ctrl, addr, data_out
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mobo_stat, data_in,
    input  f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, mobo_ctrl, addr, data_out
  );
endinterface

// File: rtl/mem_bus_arb.sv
// Two-input round-robin arbiter (F vs D) with one-hot grant (bit0 = F, bit1 = D).
// Grant is combinational from req and last_grant; last_grant registers when en is high.
// On a tie the requester that did not win last time is granted; last_grant resets to F.
module mem_bus_arb
  import mem_bus_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_f,
  input  logic       req_d,
  output logic [1:0] grant
);

  grant_t last_grant;

  // Pick a winner: single requester wins outright, a tie goes to the other side.
  always_comb begin
    grant = 2'b00;
    if (req_f && req_d) begin
      grant = (last_grant == GNT_F) ? 2'b10 : 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end else if (req_f) begin
      grant = 2'b01;
    end
  end

  // Remember who won, only when the controller actually takes the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_F;
    end else if (en && (grant != 2'b00)) begin
      last_grant <= grant[GNT_D] ? GNT_D : GNT_F;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shares one motherboard bus between fetch (F, read-only) and data (D) requesters.
// Latency: grant at edge N, READY at N+1 gives ack in the following cycle; 3-cycle minimum period.
// Waits for READY up to `timeout` BUS cycles, then aborts with err; requesters hold req until ack.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int word_width = 32,
  parameter int timeout    = 255,
  parameter int to_width   = 8
) (
  input logic           clk,
  input logic           rst,
  mem_bus_ctrl_if.slave bus
);

  localparam logic [to_width-1:0] TO_LAST = to_width'(timeout - 1);

  state_t                state;
  logic                  gnt_d_q;
  logic                  we_q;
  logic [to_width-1:0]   cnt;
  logic [1:0]            grant;
  logic                  d_write;
  logic [word_width-1:0] strobe_nxt;
  logic                  unused_stat;

  assign unused_stat = ^bus.mobo_stat[word_width-1:2];

  mem_bus_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_IDLE),
    .req_f (bus.f_req),
    .req_d (bus.d_req),
    .grant (grant)
  );

  // Direction and strobe for the transaction about to be granted.
  always_comb begin
    d_write    = grant[GNT_D] && bus.d_we;
    strobe_nxt = '0;
    if (d_write) begin
      strobe_nxt[CTRL_WR] = 1'b1;
    end else begin
      strobe_nxt[CTRL_RD] = 1'b1;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      gnt_d_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt          <= '0;
      bus.f_ack    <= 1'b0;
      bus.f_err    <= 1'b0;
      bus.f_rdata  <= '0;
      bus.d_ack    <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.d_rdata  <= '0;
      bus.mobo_ctrl <= '0;
      bus.addr     <= '0;
      bus.data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            gnt_d_q       <= grant[GNT_D];
            we_q          <= d_write;
            bus.addr      <= grant[GNT_D] ? bus.d_addr : bus.f_addr;
            bus.data_out  <= d_write ? bus.d_wdata : '0;
            bus.mobo_ctrl <= strobe_nxt;
            cnt           <= '0;
            state         <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus.mobo_stat[STAT_READY]) begin
            bus.mobo_ctrl <= '0;
            if (gnt_d_q) begin
              bus.d_ack <= 1'b1;
              bus.d_err <= bus.mobo_stat[STAT_ERROR];
              if (!we_q) bus.d_rdata <= bus.data_in;
            end else begin
              bus.f_ack   <= 1'b1;
              bus.f_err   <= bus.mobo_stat[STAT_ERROR];
              bus.f_rdata <= bus.data_in;
            end
            state <= ST_DONE;
          end else if (cnt == TO_LAST) begin
            // Abort: report error, leave rdata as it was.
            bus.mobo_ctrl <= '0;
            if (gnt_d_q) begin
              bus.d_ack <= 1'b1;
              bus.d_err <= 1'b1;
            end else begin
              bus.f_ack <= 1'b1;
              bus.f_err <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          bus.f_ack <= 1'b0;
          bus.f_err <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.d_err <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a scoreboard of expected acks is filled as
// requests are driven and drained by a monitor whenever an ack pulses.
// Bus pins and waveform-level timing are checked inline in the directed sequence.
module tb_mem_bus_ctrl;

  typedef struct {
    logic        port_d;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   ack_cnt;
  int   ack_start;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] f_model;
  logic [31:0] d_model;

  mem_bus_ctrl_if #(.word_width(32)) bus ();

  mem_bus_ctrl #(
    .word_width (32),
    .timeout    (8),
    .to_width   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port_d, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.port_d = port_d;
    e.err    = err;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  // Monitor: every ack pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst === 1'b1 && (bus.f_ack === 1'b1 || bus.d_ack === 1'b1)) begin
      ack_cnt++;
      chk("ack_exclusive", 32'(bus.f_ack & bus.d_ack), 32'd0);
      checks++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL unexpected_ack observed=f%b/d%b expected=none", bus.f_ack, bus.d_ack);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(bus.d_ack), 32'(mon_e.port_d));
        chk("ack_err", 32'(bus.d_ack ? bus.d_err : bus.f_err), 32'(mon_e.err));
        chk("ack_rdata", bus.d_ack ? bus.d_rdata : bus.f_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks  = 0;
    fails   = 0;
    ack_cnt = 0;
    rst = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mobo_stat = '0; bus.data_in = '0;
    f_model = '0;
    d_model = '0;

    // Reset state
    #1;
    chk("rst_mobo_ctrl", bus.mobo_ctrl, 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_f_ack", 32'(bus.f_ack), 32'h0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
    chk("rst_f_rdata", bus.f_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // Contention with READY held high: D,F,D,F, four acks in 12 cycles
    bus.f_addr = 32'h80; bus.d_addr = 32'h40; bus.d_we = 1'b0;
    bus.data_in = 32'hA5A5_0001; bus.mobo_stat = 32'h1;
    push(1'b1, 1'b0, 32'hA5A5_0001);
    push(1'b0, 1'b0, 32'hA5A5_0001);
    push(1'b1, 1'b0, 32'hA5A5_0001);
    push(1'b0, 1'b0, 32'hA5A5_0001);
    f_model = 32'hA5A5_0001; d_model = 32'hA5A5_0001;
    ack_start = ack_cnt;
    bus.f_req = 1'b1; bus.d_req = 1'b1;
    tick();
    chk("tie_first_goes_d_addr", bus.addr, 32'h40);
    chk("tie_first_strobe", bus.mobo_ctrl, 32'h1);
    repeat (11) tick();
    bus.f_req = 1'b0; bus.d_req = 1'b0; bus.mobo_stat = '0;
    tick();
    chk("contention_ack_count", 32'(ack_cnt - ack_start), 32'd4);
    chk("contention_sb_empty", 32'(sb.size()), 32'd0);

    // Fetch only, READY on the next edge
    bus.f_addr = 32'h100;
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    f_model = 32'hDEAD_BEEF;
    bus.f_req = 1'b1;
    tick();
    chk("fetch_strobe", bus.mobo_ctrl, 32'h1);
    chk("fetch_addr", bus.addr, 32'h100);
    bus.mobo_stat = 32'h1; bus.data_in = 32'hDEAD_BEEF;
    tick();
    chk("fetch_strobe_drop", bus.mobo_ctrl, 32'h0);
    chk("fetch_ack", 32'(bus.f_ack), 32'h1);
    bus.f_req = 1'b0; bus.mobo_stat = '0;
    tick();
    chk("fetch_ack_one_cycle", 32'(bus.f_ack), 32'h0);

    // Data write with four wait states; inputs changed in BUS are ignored
    bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
    push(1'b1, 1'b0, d_model);
    bus.d_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("write_strobe", bus.mobo_ctrl, 32'h2);
      chk("write_data_out", bus.data_out, 32'h55);
      chk("write_addr", bus.addr, 32'h20);
      if (i == 0) begin
        bus.d_wdata = 32'hFF; bus.d_addr = 32'h99;
      end
      if (i == 4) bus.mobo_stat = 32'h1;
    end
    tick();
    chk("write_strobe_drop", bus.mobo_ctrl, 32'h0);
    chk("write_ack", 32'(bus.d_ack), 32'h1);
    bus.d_req = 1'b0; bus.mobo_stat = '0; bus.d_we = 1'b0;
    tick();
    chk("write_ack_one_cycle", 32'(bus.d_ack), 32'h0);

    // Bus error on a data read still captures data_in
    bus.d_addr = 32'h30; bus.data_in = 32'h1234_5678;
    push(1'b1, 1'b1, 32'h1234_5678);
    d_model = 32'h1234_5678;
    bus.d_req = 1'b1;
    tick();
    chk("err_strobe", bus.mobo_ctrl, 32'h1);
    bus.mobo_stat = 32'h3;
    tick();
    chk("err_ack", 32'(bus.d_ack), 32'h1);
    chk("err_flag", 32'(bus.d_err), 32'h1);
    bus.d_req = 1'b0; bus.mobo_stat = '0;
    tick();

    // Timeout: strobe held for exactly 8 BUS cycles, then ack with err
    bus.f_addr = 32'h200; bus.data_in = 32'hBAD0_BAD0;
    push(1'b0, 1'b1, f_model);
    bus.f_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("timeout_strobe_held", bus.mobo_ctrl, 32'h1);
    end
    tick();
    chk("timeout_strobe_drop", bus.mobo_ctrl, 32'h0);
    chk("timeout_ack", 32'(bus.f_ack), 32'h1);
    chk("timeout_err", 32'(bus.f_err), 32'h1);
    bus.f_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a D read
    bus.d_we = 1'b0; bus.d_addr = 32'h44;
    bus.d_req = 1'b1;
    tick();
    chk("pre_reset_strobe", bus.mobo_ctrl, 32'h1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_strobe", bus.mobo_ctrl, 32'h0);
    chk("async_reset_addr", bus.addr, 32'h0);
    bus.d_req = 1'b0;
    tick();
    chk("reset_no_d_ack", 32'(bus.d_ack), 32'h0);
    tick();
    chk("reset_no_f_ack", 32'(bus.f_ack), 32'h0);
    rst = 1'b1;
    bus.f_addr = 32'h88; bus.d_addr = 32'h44;
    bus.data_in = 32'h0BAD_F00D; bus.mobo_stat = 32'h1;
    push(1'b1, 1'b0, 32'h0BAD_F00D);
    bus.f_req = 1'b1; bus.d_req = 1'b1;
    tick();
    chk("tie_after_reset_addr", bus.addr, 32'h44);
    tick();
    chk("tie_after_reset_ack", 32'(bus.d_ack), 32'h1);
    bus.f_req = 1'b0; bus.d_req = 1'b0; bus.mobo_stat = '0;
    tick(); tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
